text_renderer: RTL and testbench
================================

Name: text_renderer

Overview:
- Read-side consumer of the text-mode frame buffer. Generates 640x480@60 VGA timing at one pixel per clock.
- Issues one frame buffer read address per pixel for an 80x30 grid of 8x16 character cells.
- Looks up glyph rows in an external synchronous font ROM.
- Produces registered RGB888, HSYNC, VSYNC and DE, all aligned to the same pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLS, 80, character columns; row stride of the buffer
- BG_COLOR, 24'h000000, colour of glyph pixels that are 0

Ports:
- iClk, input, 1, pixel clock
- nRst, input, 1, synchronous active-low reset
- oRAddr, output, 32, frame buffer read address; bits [31:12] are always 0
- iRData, input, 32, frame buffer word, combinational from oRAddr. [31:8] is foreground RGB888, [7:0] is the character code
- oFontAddr, output, 12, font ROM address {char[7:0], glyph_row[3:0]}
- iFontData, input, 8, glyph row, valid one clock after oFontAddr. Bit 7 is the leftmost pixel
- oR, oG, oB, output, 8 each, pixel colour
- oHSync, output, 1, active low
- oVSync, output, 1, active low
- oDE, output, 1, high in the active area
- oFrameStart, output, 1, one-cycle pulse with pixel (0,0) on the outputs

Behaviour:
- Clock and reset: one clock, iClk. nRst is synchronous and active-low, sampled on the rising edge of iClk.
- Reset values:
  - h and v counters: 0
  - all pipeline registers: 0; delayed syncs: 1
  - oR/oG/oB: 0; oDE: 0; oFrameStart: 0
  - oHSync and oVSync: 1
- Counters:
  - h counts 0..799 and wraps to 0.
  - v increments when h wraps, counts 0..524 and wraps to 0.
  - Reset mid-frame restarts the frame at (0,0) on the next active edge. No partial pixels are emitted after reset.
- Stage 0 (combinational from the counters):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_n = 0 for h in 656..751; vs_n = 0 for v in 490..491.
  - When active, oRAddr = (v>>4)*COLS + (h>>3). Implement the multiply as (r<<6)+(r<<4). Range is 0..2399.
  - Outside the active area, oRAddr = 0.
- Stage 1 (registered):
  - Register char = iRData[7:0], fg = iRData[31:8], glyph_row = v[3:0], bit index = h[2:0], and active/hs_n/vs_n/frame_start.
  - oFontAddr = {char, glyph_row}, driven from the stage-1 registers.
- Stage 2 (registered): carry fg, bit index and control bits forward while the font ROM returns iFontData.
- Stage 3 (output registers):
  - pix = iFontData[7 - bit index].
  - If active and pix = 1, RGB = fg. If active and pix = 0, RGB = BG_COLOR. If not active, RGB = 0.
  - oDE, oHSync, oVSync and oFrameStart come from the stage-2 copies.
- Latency:
  - The pixel whose counters are (h,v) in cycle t appears on all outputs after the edge ending cycle t+2, i.e. 3 edges.
  - Syncs and DE carry the same 3-cycle delay, so alignment is exact.
- Frame start: frame_start = (h==0 && v==0) at stage 0. It is pulsed for exactly one cycle per 420000 clocks.
- Address stability: oRAddr changes only at cell boundaries inside a line and never exceeds 2399.
- Data semantics:
  - A zero word (uninitialised cell) renders glyph 0 with fg 000000, i.e. no special casing.
  - Writes to the buffer during scan are visible from the next read of that cell. No tearing protection.

Test Plan:
- Reset: hold nRst=0 for 5 clocks -> oDE=0, RGB=0, oHSync=oVSync=1, oFrameStart=0. Release -> first oDE=1 three edges after release, and oFrameStart=1 on that same cycle.
- Timing: run 2 frames -> line period 800, frame period 420000. oHSync low for 96 clocks starting 656 pixels after the line's first DE. oVSync low for lines 490-491. Exactly 640 DE-high cycles per active line, 480 active lines.
- Addressing: at (h,v)=(0,0) oRAddr=0; (8,16) -> 81; (15,31) -> 81; (639,479) -> 2399; h=700 -> 0. Check oFontAddr={char,v[3:0]} one cycle after each of these.
- Rendering: model cell 0 = 32'hFF000041 and font[{8'h41,4'h0}] = 8'h81 -> line 0 pixels 0 and 7 = FF0000, pixels 1-6 = BG_COLOR, each appearing 3 cycles after the counter value.
- Blanking: force iRData=32'hFFFFFFFF and iFontData=8'hFF throughout -> RGB=0 whenever oDE=0, FFFFFF whenever oDE=1.
- Reset mid-frame: assert nRst=0 for 1 clock at (h,v)=(300,200) -> outputs return to reset values on the next edge. Counters restart at (0,0) and oFrameStart pulses 3 edges after release.

Source files
------------

// File: rtl/text_renderer.sv
// Text-mode renderer: 640x480@60 VGA timing, 80x30 cells of 8x16,
// frame buffer fetch, synchronous font ROM lookup, registered RGB888.
// Ports:
//   iClk, nRst            pixel clock, synchronous active-low reset
//   oRAddr / iRData       frame buffer read address and word
//                         ({fg[23:0], char[7:0]}, combinational)
//   oFontAddr / iFontData font ROM {char, glyph_row} and glyph row
//                         (data one clock after address, bit 7 = left)
//   oR, oG, oB            pixel colour
//   oHSync, oVSync        active-low syncs
//   oDE                   active area
//   oFrameStart           pulse with pixel (0,0) on the outputs
module text_renderer #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          COLS     = 80,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        iClk,
  input  logic        nRst,
  output logic [31:0] oRAddr,
  input  logic [31:0] iRData,
  output logic [11:0] oFontAddr,
  input  logic [7:0]  iFontData,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oDE,
  output logic        oFrameStart
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT =
    10'(H_ACTIVE);
  localparam logic [9:0] V_ACT =
    10'(V_ACTIVE);
  localparam logic [9:0] H_SS =
    10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE =
    10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS =
    10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE =
    10'(V_ACTIVE + V_FP + V_SYNC);

  // Raster counters
  logic [9:0] h_q;
  logic [9:0] h_d;
  logic [9:0] v_q;
  logic [9:0] v_d;

  // Stage 0 (combinational)
  logic        s0_act;
  logic        s0_hs;
  logic        s0_vs;
  logic        s0_fs;
  logic [5:0]  s0_row;
  logic [6:0]  s0_col;
  logic [11:0] s0_cell;

  // Stage 1
  logic [7:0]  s1_char_q;
  logic [23:0] s1_fg_q;
  logic [3:0]  s1_grow_q;
  logic [2:0]  s1_bit_q;
  logic        s1_act_q;
  logic        s1_hs_q;
  logic        s1_vs_q;
  logic        s1_fs_q;

  // Stage 2
  logic [23:0] s2_fg_q;
  logic [2:0]  s2_bit_q;
  logic        s2_act_q;
  logic        s2_hs_q;
  logic        s2_vs_q;
  logic        s2_fs_q;

  // Stage 3
  logic        pix;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;
  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  assign s0_act = (h_q < H_ACT)
               && (v_q < V_ACT);
  assign s0_hs  = !((h_q >= H_SS)
               && (h_q < H_SE));
  assign s0_vs  = !((v_q >= V_SS)
               && (v_q < V_SE));
  assign s0_fs  = (h_q == '0)
               && (v_q == '0);

  assign s0_row = v_q[9:4];
  assign s0_col = h_q[9:3];

  // row * 80 as (row << 6) + (row << 4)
  generate
    if (COLS == 80) begin : g_mul80
      assign s0_cell =
          {s0_row, 6'b0}
        + {2'b0, s0_row, 4'b0}
        + {5'b0, s0_col};
    end else begin : g_mul
      assign s0_cell =
          12'(32'(s0_row) * COLS)
        + {5'b0, s0_col};
    end
  endgenerate

  assign oRAddr = s0_act
    ? {20'b0, s0_cell}
    : 32'b0;

  assign oFontAddr = {s1_char_q, s1_grow_q};

  assign pix = iFontData[3'd7 - s2_bit_q];

  always_comb begin
    rgb_d = 24'h0;
    if (s2_act_q) begin
      rgb_d = pix ? s2_fg_q : BG_COLOR;
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      h_q       <= '0;
      v_q       <= '0;
      s1_char_q <= '0;
      s1_fg_q   <= '0;
      s1_grow_q <= '0;
      s1_bit_q  <= '0;
      s1_act_q  <= 1'b0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      s1_fs_q   <= 1'b0;
      s2_fg_q   <= '0;
      s2_bit_q  <= '0;
      s2_act_q  <= 1'b0;
      s2_hs_q   <= 1'b1;
      s2_vs_q   <= 1'b1;
      s2_fs_q   <= 1'b0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      s1_char_q <= iRData[7:0];
      s1_fg_q   <= iRData[31:8];
      s1_grow_q <= v_q[3:0];
      s1_bit_q  <= h_q[2:0];
      s1_act_q  <= s0_act;
      s1_hs_q   <= s0_hs;
      s1_vs_q   <= s0_vs;
      s1_fs_q   <= s0_fs;
      // font ROM read is in flight here
      s2_fg_q   <= s1_fg_q;
      s2_bit_q  <= s1_bit_q;
      s2_act_q  <= s1_act_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_fs_q   <= s1_fs_q;
      rgb_q     <= rgb_d;
      de_q      <= s2_act_q;
      hs_q      <= s2_hs_q;
      vs_q      <= s2_vs_q;
      fs_q      <= s2_fs_q;
    end
  end

  assign oR          = rgb_q[23:16];
  assign oG          = rgb_q[15:8];
  assign oB          = rgb_q[7:0];
  assign oDE         = de_q;
  assign oHSync      = hs_q;
  assign oVSync      = vs_q;
  assign oFrameStart = fs_q;

endmodule

// File: tb/tb_text_renderer.sv
// Scoreboard bench for text_renderer with a shortened vertical
// raster; frame buffer and font ROM are modelled here.
module tb_text_renderer;

  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int VA = 32;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam logic [27:0] RST =
    {1'b1 ^ 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] oRAddr;
  logic [31:0] iRData;
  logic [11:0] oFontAddr;
  logic [7:0]  iFontData;
  logic [7:0]  oR;
  logic [7:0]  oG;
  logic [7:0]  oB;
  logic        oHSync;
  logic        oVSync;
  logic        oDE;
  logic        oFrameStart;

  always #5 iClk = ~iClk;

  text_renderer #(
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .iClk        (iClk),
    .nRst        (nRst),
    .oRAddr      (oRAddr),
    .iRData      (iRData),
    .oFontAddr   (oFontAddr),
    .iFontData   (iFontData),
    .oR          (oR),
    .oG          (oG),
    .oB          (oB),
    .oHSync      (oHSync),
    .oVSync      (oVSync),
    .oDE         (oDE),
    .oFrameStart (oFrameStart)
  );

  logic [31:0] fb [0:2399];
  logic [7:0]  font [0:4095];
  logic [7:0]  font_q;
  bit          ff_mode = 1'b0;
  bit          mon_en = 1'b0;

  always @(posedge iClk) font_q <= font[oFontAddr];

  assign iRData = ff_mode ? 32'hFFFF_FFFF
    : (oRAddr < 32'd2400 ? fb[oRAddr[11:0]] : 32'h0);
  assign iFontData = ff_mode ? 8'hFF : font_q;

  typedef struct {
    int          h;
    int          v;
    logic [27:0] e;
  } ent_t;

  ent_t q[$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] model(int h, int v);
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [31:0] w;
    logic [7:0]  g;
    logic [11:0] fa;
    logic [23:0] rgb;
    int          a;
    act = (h < HA) && (v < VA);
    hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    fs  = (h == 0) && (v == 0);
    rgb = 24'h0;
    if (act) begin
      a   = (v / 16) * 80 + h / 8;
      w   = ff_mode ? 32'hFFFF_FFFF : fb[a];
      fa  = {w[7:0], 4'(v % 16)};
      g   = ff_mode ? 8'hFF : font[fa];
      rgb = g[7 - (h % 8)] ? w[31:8] : 24'h0;
    end
    return {act, hs, vs, fs, rgb};
  endfunction

  function automatic logic [27:0] obs();
    return {oDE, oHSync, oVSync, oFrameStart, oR, oG, oB};
  endfunction

  int   th = 0;
  int   tv = 0;
  int   cyc = 0;
  bit   fa_pend = 1'b0;
  logic [11:0] fa_exp;
  string fa_tag;

  int ah [5] = '{0, 8, 15, 639, 700};
  int av [5] = '{0, 16, 31, 31, 5};
  int ea [5] = '{0, 81, 81, 159, 0};
  logic [11:0] ef [5] =
    '{12'h410, 12'h5A0, 12'h5AF, 12'h77F, 12'h415};

  logic pde = 1'b0;
  logic phs = 1'b1;
  logic pvs = 1'b1;
  int fs_last  = -1;
  int de_rise  = -1;
  int de_lines = 0;
  int hs_fall  = -1;
  int vs_fall  = -1;

  task automatic monitor();
    if (oFrameStart) begin
      if (fs_last >= 0) begin
        chk("frame_period", cyc - fs_last, FRAME);
        chk("active_lines", de_lines, VA);
      end
      fs_last  = cyc;
      de_lines = 0;
    end
    if (oDE && !pde) begin
      if (de_lines > 0)
        chk("line_period", cyc - de_rise, HT);
      de_rise = cyc;
      de_lines++;
    end
    if (!oDE && pde)
      chk("de_len", cyc - de_rise, HA);
    if (!oHSync && phs) begin
      hs_fall = cyc;
      if (de_rise >= 0 && cyc - de_rise < HT)
        chk("hs_start", cyc - de_rise, HA + HF);
    end
    if (oHSync && !phs && hs_fall >= 0)
      chk("hs_len", cyc - hs_fall, HS);
    if (!oVSync && pvs) begin
      vs_fall = cyc;
      if (fs_last >= 0)
        chk("vs_start", cyc - fs_last, (VA + VF) * HT);
    end
    if (oVSync && !pvs && vs_fall >= 0)
      chk("vs_len", cyc - vs_fall, VS * HT);
    pde = oDE;
    phs = oHSync;
    pvs = oVSync;
  endtask

  task automatic step();
    logic r;
    ent_t e;
    r = nRst;
    @(posedge iClk);
    #1;
    cyc++;
    if (!r) begin
      q.delete();
      th = 0;
      tv = 0;
      fa_pend = 1'b0;
      chk("rst_out", obs(), RST);
      q.push_back('{-1, -1, RST});
      q.push_back('{-1, -1, RST});
    end else begin
      th++;
      if (th == HT) begin
        th = 0;
        tv++;
        if (tv == VT) tv = 0;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("pix h=%0d v=%0d", e.h, e.v),
            obs(), e.e);
        if (!ff_mode && e.v == 0 && e.h >= 0 && e.h < 8)
          chk($sformatf("line0 px%0d", e.h),
              {oR, oG, oB},
              (e.h == 0 || e.h == 7) ? 24'hFF0000 : 24'h0);
        if (ff_mode)
          chk("blank_rgb", {oR, oG, oB},
              oDE ? 24'hFFFFFF : 24'h0);
      end
      if (fa_pend)
        chk(fa_tag, oFontAddr, fa_exp);
      fa_pend = 1'b0;
      if (mon_en) monitor();
    end
    if (!ff_mode) begin
      for (int i = 0; i < 5; i++) begin
        if (th == ah[i] && tv == av[i]) begin
          chk($sformatf("raddr %0d,%0d", th, tv),
              oRAddr, ea[i]);
          fa_pend = 1'b1;
          fa_exp  = ef[i];
          fa_tag  = $sformatf("faddr %0d,%0d", th, tv);
        end
      end
    end
    q.push_back('{th, tv, model(th, tv)});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2400; i++) fb[i] = $urandom;
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    fb[0]   = 32'hFF00_0041;
    fb[1]   = 32'h0;
    fb[81]  = 32'h12AB_CD5A;
    fb[159] = 32'h0012_3477;
    font[12'h410] = 8'h81;

    nRst = 1'b0;
    repeat (5) step();
    nRst = 1'b1;
    mon_en = 1'b1;
    step();
    chk("de_rel1", oDE, 1'b0);
    step();
    chk("de_rel2", oDE, 1'b0);
    step();
    chk("de_rel3", oDE, 1'b1);
    chk("fs_rel3", oFrameStart, 1'b1);

    repeat (FRAME) step();
    n = 0;
    while (!(th == 300 && tv == 20) && n < FRAME) begin
      step();
      n++;
    end
    chk("reach_mid", (th == 300 && tv == 20), 1'b1);

    nRst = 1'b0;
    step();
    nRst = 1'b1;
    mon_en = 1'b0;
    step();
    chk("fs_mid1", oFrameStart, 1'b0);
    step();
    step();
    chk("fs_mid3", oFrameStart, 1'b1);
    repeat (2000) step();

    nRst = 1'b0;
    ff_mode = 1'b1;
    step();
    nRst = 1'b1;
    repeat (2000) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
